// File: rtl/req_demux_1to2_if.sv
// Bundle of the core-side request/response channel and both target ports.
// slave is the demux view; master is the core/target environment view.
interface req_demux_1to2_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_we;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic        s_err;

    logic        m0_valid;
    logic        m0_ready;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_we;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_valid;
    logic        m1_ready;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_we;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    modport slave (
        input  s_valid, s_addr, s_wdata, s_we,
        output s_ready, s_rvalid, s_rdata, s_err,
        output m0_valid, m0_addr, m0_wdata, m0_we,
        input  m0_ready, m0_rvalid, m0_rdata,
        output m1_valid, m1_addr, m1_wdata, m1_we,
        input  m1_ready, m1_rvalid, m1_rdata
    );

    modport master (
        output s_valid, s_addr, s_wdata, s_we,
        input  s_ready, s_rvalid, s_rdata, s_err,
        input  m0_valid, m0_addr, m0_wdata, m0_we,
        output m0_ready, m0_rvalid, m0_rdata,
        input  m1_valid, m1_addr, m1_wdata, m1_we,
        output m1_ready, m1_rvalid, m1_rdata
    );
endinterface

// File: rtl/req_demux_1to2.sv
// Registered 1:2 data-memory request demux, one transaction in flight.
// Define DEMUX_TIMEOUT_EN to turn a hung target into an error response.
module req_demux_1to2 #(
    parameter logic [31:0] SEL_BASE = 32'h1000_0000,
    parameter logic [31:0] SEL_MASK = 32'hF000_0000,
    parameter int          TIMEOUT  = 16
) (
    input logic             clk,
    input logic             rst,
    req_demux_1to2_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state, state_n;
    logic [31:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic        we_q, we_n;
    logic        sel_q, sel_n;
    logic [31:0] rdata_q, rdata_n;
    logic        err_q, err_n;

    logic        sel_ready;
    logic        sel_rvalid;
    logic [31:0] resp_data;
    logic        expired;

    assign sel_ready  = sel_q ? bus.m1_ready  : bus.m0_ready;
    assign sel_rvalid = sel_q ? bus.m1_rvalid : bus.m0_rvalid;
    // Writes return no data even if the target drives its bus.
    assign resp_data  = we_q ? 32'h0 :
                        (sel_q ? bus.m1_rdata : bus.m0_rdata);

`ifdef DEMUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CW'(1);
    assign expired = (state == WAIT) && !sel_rvalid && (cnt_inc == TO_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state == ISSUE) begin
            cnt_q <= '0;
        end else if (state == WAIT && !sel_rvalid) begin
            cnt_q <= cnt_inc;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign expired        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            we_q    <= we_n;
            sel_q   <= sel_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        we_n    = we_q;
        sel_n   = sel_q;
        rdata_n = rdata_q;
        err_n   = err_q;
        unique case (state)
            IDLE: begin
                if (bus.s_valid) begin
                    addr_n  = bus.s_addr;
                    wdata_n = bus.s_wdata;
                    we_n    = bus.s_we;
                    sel_n   = ((bus.s_addr & SEL_MASK) == SEL_BASE);
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (sel_ready && sel_rvalid) begin
                    rdata_n = resp_data;
                    err_n   = 1'b0;
                    state_n = RESP;
                end else if (sel_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                // A response in the expiry cycle still wins over the error.
                if (sel_rvalid) begin
                    rdata_n = resp_data;
                    err_n   = 1'b0;
                    state_n = RESP;
                end else if (expired) begin
                    rdata_n = '0;
                    err_n   = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.s_ready  = (state == IDLE);
    assign bus.s_rvalid = (state == RESP);
    assign bus.s_rdata  = rdata_q;
    assign bus.s_err    = err_q;

    assign bus.m0_valid = (state == ISSUE) && !sel_q;
    assign bus.m1_valid = (state == ISSUE) && sel_q;
    assign bus.m0_addr  = addr_q;
    assign bus.m1_addr  = addr_q;
    assign bus.m0_wdata = wdata_q;
    assign bus.m1_wdata = wdata_q;
    assign bus.m0_we    = we_q;
    assign bus.m1_we    = we_q;

endmodule

// File: doc/req_demux_1to2.md
# req_demux_1to2

Registered 1:2 request demultiplexer for the data-memory path. It accepts a single request stream from the core and steers it to one of two targets: port 0 for main RAM, port 1 for the PMP CSR/MMIO window, chosen by an address-window compare. It returns the selected target's response to the core. One transaction is in flight at a time, and an optional timeout converts a hung target into an error response.

## Interface
- SEL_BASE, 32'h1000_0000, base address of the port-1 window
- SEL_MASK, 32'hF000_0000, mask applied before the window compare
- TIMEOUT, 16, cycles waited for a target response before error (≥1; used only with DEMUX_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  core request valid
- s_ready  out  1  core request accepted this cycle
- s_addr  in  32  request address
- s_wdata  in  32  write data
- s_we  in  1  1 = write, 0 = read
- s_rvalid  out  1  response valid, single-cycle pulse
- s_rdata  out  32  read data (0 for writes and errors)
- s_err  out  1  timeout error flag, qualified by s_rvalid
- m0_valid / m1_valid  out  1  target request valid
- m0_ready / m1_ready  in  1  target accepts request
- m0_addr / m1_addr  out  32  registered address
- m0_wdata / m1_wdata  out  32  registered write data
- m0_we / m1_we  out  1  registered write enable
- m0_rvalid / m1_rvalid  in  1  target response or write acknowledge
- m0_rdata / m1_rdata  in  32  target read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - s_ready=1.
  - On s_valid: latch addr, wdata and we; latch sel = ((s_addr & SEL_MASK) == SEL_BASE); go to ISSUE.
- **ISSUE**
  - m{sel}_valid=1 with the latched fields, held stable until m{sel}_ready.
  - The other port's valid stays 0.
  - On ready with rvalid in the same cycle: capture rdata and go to RESP.
  - On ready alone: go to WAIT.
- **WAIT**
  - m{sel}_valid=0.
  - On m{sel}_rvalid: capture m{sel}_rdata (forced to 0 if the latched we=1), set err=0, go to RESP.
- **RESP**
  - s_rvalid=1 for exactly one cycle, with s_rdata and s_err valid.
  - Next state is IDLE.
- s_ready is 1 only in IDLE. A request is never accepted while another is in flight.
- rvalid on the unselected port is ignored in every state. rvalid on either port is ignored in IDLE and RESP.
- m*_addr, m*_wdata and m*_we of both ports carry the latched values. Only the valid signal is demultiplexed.
- Writes always produce one response. The target signals completion with rvalid.

## Timing
- Reset values (outputs next edge after rst=1): state=IDLE, s_ready=1, s_rvalid=0, s_err=0, s_rdata=0, m0_valid=m1_valid=0, latched fields=0, timeout counter=0.
- Reset mid-transaction aborts immediately: no response is emitted, and a late rvalid afterwards is ignored.
- Minimum latency, s_valid accepted to s_rvalid:
  - 2 cycles when the target has ready and rvalid high in its first ISSUE cycle (IDLE→ISSUE→RESP).
  - 3 cycles otherwise.
- Throughput: at most one transaction per 3 cycles.
- s_valid in the RESP cycle is not accepted. It is accepted in the following IDLE cycle.
- Timeout counter:
  - Width $clog2(TIMEOUT+1); cleared on entry to WAIT; increments each WAIT cycle without rvalid.
  - When it reaches TIMEOUT, go to RESP with s_err=1 and s_rdata=0.
  - rvalid arriving in the same cycle the count reaches TIMEOUT wins: normal response, err=0.

## Configuration
- DEMUX_TIMEOUT_EN defined:
  - Timeout counter present.
  - A hung target yields an error response after TIMEOUT WAIT cycles.
- Not defined:
  - No counter; WAIT holds indefinitely until rvalid.
  - s_err is tied to 0.
  - TIMEOUT is unused.

## Test plan
- Read to addr 0x0000_0040, m0 ready immediately, rvalid one cycle later with 0xDEAD_BEEF -> only m0_valid pulses; s_rvalid 3 cycles after acceptance with s_rdata=0xDEAD_BEEF, s_err=0.
- Write 0x1000_0008 data 0x0000_00FF, m1 ready and rvalid in the same cycle -> m1_valid/m1_we=1, m1_wdata=0xFF; s_rvalid 2 cycles after acceptance, s_rdata=0; m0_valid never asserts.
- Read to 0x1000_0000, m1_ready low for 5 cycles -> m1_valid and m1_addr held stable 5 cycles; s_ready=0 throughout; a second s_valid is not accepted.
- DEMUX_TIMEOUT_EN, TIMEOUT=16, m0 accepts and never responds -> s_rvalid with s_err=1, s_rdata=0 after 16 WAIT cycles; the following request completes normally.
- Spurious m1_rvalid=1 with rdata 0x1234 during an m0 read -> ignored; s_rdata reflects m0 data only.
- rst pulsed for one cycle while in WAIT, then target rvalid -> no s_rvalid; state IDLE with s_ready=1 the cycle after reset.
